// File: rtl/alu_issue_if.sv
// alu_issue_if: instruction valid/ready channel into the issue stage
interface alu_issue_if #(parameter int OPCODE_SIZE = 4, parameter int REG_AW = 2);
  logic                   valid;
  logic                   ready;
  logic [OPCODE_SIZE-1:0] op;
  logic [REG_AW-1:0]      rd;
  logic [REG_AW-1:0]      rs1;
  logic [REG_AW-1:0]      rs2;
  logic                   use_carry;
  modport master(output valid, op, rd, rs1, rs2, use_carry, input ready);
  modport slave(input valid, op, rd, rs1, rs2, use_carry, output ready);
endinterface

// File: rtl/alu_issue.sv
// alu_issue: issue/writeback stage wrapping a one-cycle registered ALU,
// with a small register file, carry flag and divide-by-zero/illegal traps.
module alu_issue #(
  parameter int BITS        = 8,
  parameter int OPCODE_SIZE = 4,
  parameter int REG_AW      = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  alu_issue_if.slave             instr,
  input  logic                   ld_en_i,
  input  logic [REG_AW-1:0]      ld_addr_i,
  input  logic [BITS-1:0]        ld_data_i,
  input  logic [REG_AW-1:0]      dbg_addr_i,
  output logic [BITS-1:0]        dbg_data_o,
  output logic [BITS-1:0]        alu_a_o,
  output logic [BITS-1:0]        alu_b_o,
  output logic [OPCODE_SIZE-1:0] alu_op_o,
  output logic                   alu_cin_o,
  input  logic [BITS-1:0]        alu_sum_i,
  input  logic                   alu_cout_i,
  output logic                   done_o,
  output logic [BITS-1:0]        done_data_o,
  output logic                   carry_flag_o,
  output logic                   div_zero_o,
  output logic                   illegal_o
);
  localparam int NREG = 1 << REG_AW;
  typedef enum logic [1:0] {IDLE, DRIVE, CAPTURE, TRAP} state_t;
  state_t            state_q, state_d;
  logic [BITS-1:0]   regs_q [NREG];
  logic [REG_AW-1:0] rd_q;
  logic              dz_q, ill_q;
  logic              hs, dz, ill, trap;
  assign instr.ready = state_q == IDLE;
  assign hs          = instr.valid && state_q == IDLE;
  assign ill         = instr.op == '0 || instr.op > OPCODE_SIZE'(12);
  assign dz          = instr.op == OPCODE_SIZE'(4) && regs_q[instr.rs2] == '0;
  assign trap        = ill || dz;
  assign dbg_data_o  = regs_q[dbg_addr_i];
  always_comb begin
    state_d = state_q == IDLE  ? (hs ? (trap ? TRAP : DRIVE) : IDLE) :
              state_q == DRIVE ? CAPTURE : IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      rd_q         <= '0;
      dz_q         <= 1'b0;
      ill_q        <= 1'b0;
      alu_a_o      <= '0;
      alu_b_o      <= '0;
      alu_op_o     <= '0;
      alu_cin_o    <= 1'b0;
      done_o       <= 1'b0;
      done_data_o  <= '0;
      carry_flag_o <= 1'b0;
      div_zero_o   <= 1'b0;
      illegal_o    <= 1'b0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      done_o     <= state_q == CAPTURE || state_q == TRAP;
      div_zero_o <= state_q == TRAP && dz_q;
      illegal_o  <= state_q == TRAP && ill_q;
      if (hs) begin
        rd_q  <= instr.rd;
        dz_q  <= dz;
        ill_q <= ill;
      end
      if (hs && !trap) begin
        alu_a_o   <= regs_q[instr.rs1];
        alu_b_o   <= regs_q[instr.rs2];
        alu_op_o  <= instr.op;
        alu_cin_o <= instr.use_carry & carry_flag_o;
      end
      if (state_q == CAPTURE) begin
        carry_flag_o <= alu_cout_i;
        done_data_o  <= alu_sum_i;
      end
      if (state_q == TRAP) done_data_o <= '0;
      // ALU writeback takes priority over an external load to the same register
      for (int i = 0; i < NREG; i++)
        if (state_q == CAPTURE && rd_q == REG_AW'(i)) regs_q[i] <= alu_sum_i;
        else if (ld_en_i && ld_addr_i == REG_AW'(i)) regs_q[i] <= ld_data_i;
    end
  end
endmodule
